interp: RTL and testbench

Streaming fixed-point interpolator: the expanding counterpart to our fixed-to-integer rounding block. It accepts signed integer samples and reconstructs a fixed-point stream with FW fraction bits. Between each pair of consecutive input samples it emits 2^K linearly interpolated fixed-point values, computed exactly. It sits downstream of integer-domain stages, feeding fixed-point datapaths (e.g. filters, DACs), with valid/ready handshakes on both sides.

---
 rtl/interp.sv | 95 +++++++++
 tb/tb_interp.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/interp.sv
// rtl/interp.sv - streaming linear interpolator, signed integer samples in, fixed-point stream out
module interp #(
   parameter int DW = 16,
   parameter int FW = 8,
   parameter int K  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DW-FW-1:0]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DW-1:0]      out_data
);

   localparam int IW = DW - FW;
   localparam logic [K:0] ILAST = (K+1)'((2**K) - 1);

   typedef enum logic [1:0] {EMPTY, IDLE, RUN} state_t;

   state_t            state, state_next;
   logic [IW-1:0]     x0, x0_next;
   logic [DW:0]       acc, step;
   logic [K:0]        i;
   logic [IW:0]       delta;
   logic [DW:0]       delta_ext, step_new, acc_start, acc_inc;
   logic              in_fire, out_fire, last;

   assign in_ready = (state != RUN);
   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign last     = (i == ILAST);

   // One extra bit on delta and acc keeps every intermediate exact.
   assign delta     = {in_data[IW-1], in_data} - {x0[IW-1], x0};
   assign delta_ext = {{FW{delta[IW]}}, delta};
   assign step_new  = delta_ext << (FW - K);
   assign acc_start = {x0[IW-1], x0, {FW{1'b0}}};
   assign acc_inc   = acc + step;

   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (in_fire) state_next = IDLE;
         IDLE:    if (in_fire) state_next = RUN;
         RUN:     if (out_fire && last) state_next = IDLE;
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         x0        <= '0;
         x0_next   <= '0;
         acc       <= '0;
         step      <= '0;
         i         <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         state <= state_next;
         case (state)
            EMPTY: begin
               if (in_fire) x0 <= in_data;
            end
            IDLE: begin
               if (in_fire) begin
                  acc       <= acc_start;
                  step      <= step_new;
                  out_data  <= acc_start[DW-1:0];
                  out_valid <= 1'b1;
                  i         <= '0;
                  x0_next   <= in_data;
               end
            end
            RUN: begin
               if (out_fire) begin
                  if (!last) begin
                     acc      <= acc_inc;
                     out_data <= acc_inc[DW-1:0];
                     i        <= i + 1'b1;
                  end else begin
                     out_valid <= 1'b0;
                     x0        <= x0_next;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_interp.sv
// tb/tb_interp.sv - directed self-checking bench for interp
module tb_interp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [7:0]  in_data;
   logic [15:0] out_data;

   logic        k0_in_valid, k0_in_ready, k0_out_valid, k0_out_ready;
   logic [7:0]  k0_in_data;
   logic [15:0] k0_out_data;

   logic        k8_in_valid, k8_in_ready, k8_out_valid, k8_out_ready;
   logic [7:0]  k8_in_data;
   logic [15:0] k8_out_data;

   int tests = 0;
   int fails = 0;

   interp #(.DW(16), .FW(8), .K(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   interp #(.DW(16), .FW(8), .K(0)) dut_k0 (
      .clk(clk), .rst(rst),
      .in_valid(k0_in_valid), .in_ready(k0_in_ready), .in_data(k0_in_data),
      .out_valid(k0_out_valid), .out_ready(k0_out_ready), .out_data(k0_out_data)
   );

   interp #(.DW(16), .FW(8), .K(8)) dut_k8 (
      .clk(clk), .rst(rst),
      .in_valid(k8_in_valid), .in_ready(k8_in_ready), .in_data(k8_in_data),
      .out_valid(k8_out_valid), .out_ready(k8_out_ready), .out_data(k8_out_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] x);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = x;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      check("send_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic expect4(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic [15:0] e3);
      logic [15:0] e [4];
      int n;
      e = '{e0, e1, e2, e3};
      out_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         n = 0;
         while (!out_valid && n < 20) begin
            tick();
            n++;
         end
         check({tag, "_valid"}, out_valid, 1);
         check({tag, "_busy"}, in_ready, 0);
         check({tag, "_data"}, out_data, e[b]);
         tick();
      end
      check({tag, "_done"}, out_valid, 0);
      check({tag, "_ready"}, in_ready, 1);
   endtask

   initial begin
      logic [15:0] bp_exp [4];
      logic [15:0] held;
      logic        stall;
      int          beats, cyc;

      rst = 1'b1;
      in_valid = 1'b0;  in_data = '0;  out_ready = 1'b0;
      k0_in_valid = 1'b0; k0_in_data = '0; k0_out_ready = 1'b0;
      k8_in_valid = 1'b0; k8_in_data = '0; k8_out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 1);

      // priming and basic ramp
      out_ready = 1'b1;
      send(8'd3);
      check("prime_no_out", out_valid, 0);
      send(8'd5);
      expect4("ramp", 16'h0300, 16'h0380, 16'h0400, 16'h0480);

      send(8'd1);
      expect4("desc", 16'h0500, 16'h0400, 16'h0300, 16'h0200);

      // full-range sign span
      rst = 1'b1;
      tick();
      rst = 1'b0;
      send(8'h80);
      check("span_prime", out_valid, 0);
      send(8'h7F);
      expect4("span", 16'h8000, 16'hBFC0, 16'hFF80, 16'h3F40);
      send(8'h80);
      expect4("span2", 16'h7F00, 16'h3F40, 16'hFF80, 16'hBFC0);

      // backpressure: pair (-128, 0), step 0x2000
      out_ready = 1'b0;
      send(8'h00);
      bp_exp = '{16'h8000, 16'hA000, 16'hC000, 16'hE000};
      beats = 0;
      cyc = 0;
      while (beats < 4 && cyc < 200) begin
         out_ready = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         stall = 1'b0;
         held = out_data;
         if (out_valid) begin
            check("bp_busy", in_ready, 0);
            if (out_ready) begin
               check("bp_data", out_data, bp_exp[beats]);
               beats++;
            end else begin
               stall = 1'b1;
            end
         end
         tick();
         if (stall) begin
            check("bp_hold_data", out_data, held);
            check("bp_hold_valid", out_valid, 1);
         end
         cyc++;
      end
      check("bp_count", beats, 4);
      check("bp_done", out_valid, 0);
      check("bp_ready", in_ready, 1);
      out_ready = 1'b1;

      // reset mid-run after two beats
      rst = 1'b1;
      tick();
      rst = 1'b0;
      send(8'd3);
      send(8'd5);
      check("mid_b0", out_data, 16'h0300);
      tick();
      check("mid_b1", out_data, 16'h0380);
      tick();
      check("mid_b2", out_data, 16'h0400);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_ready", in_ready, 1);
      check("mid_rst_data", out_data, 0);
      send(8'd7);
      check("mid_reprime", out_valid, 0);
      send(8'd9);
      expect4("rerun", 16'h0700, 16'h0780, 16'h0800, 16'h0880);

      // K=0: one output per pair
      k0_in_valid = 1'b1;
      k0_in_data = 8'd4;
      tick();
      k0_in_data = 8'd6;
      tick();
      k0_in_valid = 1'b0;
      check("k0_valid", k0_out_valid, 1);
      check("k0_data", k0_out_data, 16'h0400);
      check("k0_busy", k0_in_ready, 0);
      k0_out_ready = 1'b1;
      tick();
      check("k0_done", k0_out_valid, 0);
      check("k0_ready", k0_in_ready, 1);

      // K=FW: 256 outputs stepping by one LSB
      k8_in_valid = 1'b1;
      k8_in_data = 8'd0;
      tick();
      k8_in_data = 8'd1;
      tick();
      k8_in_valid = 1'b0;
      k8_out_ready = 1'b1;
      for (int b = 0; b < 256; b++) begin
         check("k8_valid", k8_out_valid, 1);
         check("k8_data", k8_out_data, 32'(b));
         tick();
      end
      check("k8_done", k8_out_valid, 0);
      check("k8_ready", k8_in_ready, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
